// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target.
// The FSM state encoding and the bus-level constants live here so the bench and RTL agree.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    // Position and level of the R/W flag inside the address byte.
    localparam int   I2C_RW_BIT   = 0;
    localparam logic I2C_RW_WRITE = 1'b0;

    // sda_oe levels: the target signals ACK by pulling SDA low.
    localparam logic I2C_OE_ACK  = 1'b1;
    localparam logic I2C_OE_NACK = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_tgt_state_e;

    function automatic logic addr_write_match(
        input logic [I2C_BYTE_W-1:0] addr_byte,
        input logic [I2C_ADDR_W-1:0] own_addr
    );
        return (addr_byte[I2C_BYTE_W-1:1] == own_addr) &&
               (addr_byte[I2C_RW_BIT] == I2C_RW_WRITE);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Oversamples the asynchronous scl/sda lines on the system clock and derives
// single-cycle edge, START and STOP pulses plus the synchronized SDA level.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det_raw
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Preset to 1 so an idle bus after reset does not look like a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    assign sda_lvl      = w_sda;
    assign scl_rise     =  w_scl & ~r_scl_prev;
    assign scl_fall     = ~w_scl &  r_scl_prev;
    assign start_det    =  w_scl &  r_scl_prev &  r_sda_prev & ~w_sda;
    assign stop_det_raw =  w_scl &  r_scl_prev & ~r_sda_prev &  w_sda;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: decodes START/address/data/STOP from the oversampled bus,
// ACKs its own write address and hands received bytes to a valid/ready stream.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TGT_ADDR    = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    input  logic                  enable,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_first,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  addr_hit,
    output logic                  stop_det,
    output logic                  overflow,
    output logic                  busy
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk          (clk),
        .rst          (rst),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .sda_lvl      (w_sda),
        .scl_rise     (w_scl_rise),
        .scl_fall     (w_scl_fall),
        .start_det    (w_start),
        .stop_det_raw (w_stop)
    );

    i2c_tgt_state_e        r_state, w_state_nxt;
    logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic [I2C_BYTE_W-1:0] r_shift, w_shift_nxt;
    logic                  r_sda_oe, w_sda_oe_nxt;
    logic                  r_ack_pend, w_ack_pend_nxt;
    logic                  r_first_flag, w_first_flag_nxt;
    logic [I2C_BYTE_W-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_rx_first, w_rx_first_nxt;
    logic                  r_addr_hit, w_addr_hit_nxt;
    logic                  r_stop_det, w_stop_det_nxt;
    logic                  r_overflow, w_overflow_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [I2C_BYTE_W-1:0] w_byte;
    logic                  w_slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_sda_oe     <= I2C_OE_NACK;
            r_ack_pend   <= 1'b0;
            r_first_flag <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_first   <= 1'b0;
            r_addr_hit   <= 1'b0;
            r_stop_det   <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
            r_ack_pend   <= w_ack_pend_nxt;
            r_first_flag <= w_first_flag_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_first   <= w_rx_first_nxt;
            r_addr_hit   <= w_addr_hit_nxt;
            r_stop_det   <= w_stop_det_nxt;
            r_overflow   <= w_overflow_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // The holding register counts as free if the consumer takes the old byte this cycle.
    assign w_byte      = {r_shift[I2C_BYTE_W-2:0], w_sda};
    assign w_slot_free = !r_rx_valid || rx_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_sda_oe_nxt     = r_sda_oe;
        w_ack_pend_nxt   = r_ack_pend;
        w_first_flag_nxt = r_first_flag;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = r_rx_valid;
        w_rx_first_nxt   = r_rx_first;
        w_addr_hit_nxt   = 1'b0;
        w_stop_det_nxt   = 1'b0;
        w_overflow_nxt   = r_overflow;
        w_busy_nxt       = r_busy;

        if (r_rx_valid && rx_ready) begin
            w_rx_valid_nxt = 1'b0;
        end

        if (w_stop) begin
            w_state_nxt    = ST_IDLE;
            w_sda_oe_nxt   = I2C_OE_NACK;
            w_ack_pend_nxt = 1'b0;
            w_stop_det_nxt = 1'b1;
            w_busy_nxt     = 1'b0;
        end else if (w_start) begin
            w_state_nxt    = ST_ADDR;
            w_bit_cnt_nxt  = '0;
            w_sda_oe_nxt   = I2C_OE_NACK;
            w_ack_pend_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (w_scl_rise && r_bit_cnt < 4'd8) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (enable && addr_write_match(w_byte, TGT_ADDR)) begin
                                w_ack_pend_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                            end
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd8 && r_ack_pend) begin
                        w_sda_oe_nxt   = I2C_OE_ACK;
                        w_ack_pend_nxt = 1'b0;
                        w_addr_hit_nxt = 1'b1;
                        w_busy_nxt     = 1'b1;
                        w_state_nxt    = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt     = I2C_OE_NACK;
                        w_bit_cnt_nxt    = '0;
                        w_first_flag_nxt = 1'b1;
                        w_state_nxt      = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_scl_rise && r_bit_cnt < 4'd8) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (w_slot_free) begin
                                w_rx_data_nxt    = w_byte;
                                w_rx_valid_nxt   = 1'b1;
                                w_rx_first_nxt   = r_first_flag;
                                w_first_flag_nxt = 1'b0;
                                w_ack_pend_nxt   = 1'b1;
                            end else begin
                                w_overflow_nxt = 1'b1;
                                w_ack_pend_nxt = 1'b0;
                            end
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_sda_oe_nxt   = r_ack_pend ? I2C_OE_ACK : I2C_OE_NACK;
                        w_ack_pend_nxt = 1'b0;
                        w_state_nxt    = ST_DATA_ACK;
                    end
                end
                ST_DATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt  = I2C_OE_NACK;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_DATA;
                    end
                end
                ST_IGNORE: begin
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_first = r_rx_first;
    assign rx_valid = r_rx_valid;
    assign addr_hit = r_addr_hit;
    assign stop_det = r_stop_det;
    assign overflow = r_overflow;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: a bit-banged I2C master drives the bus and
// expected stream bytes go through a scoreboard queue checked at each handshake.
module tb_i2c_target_rx;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclM = 1'b1;
    logic       sdaM = 1'b1;
    logic       enable = 1'b1;
    logic       rx_ready = 1'b1;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       rx_valid;
    logic       addr_hit;
    logic       stop_det;
    logic       overflow;
    logic       busy;
    wire        sdaBus = sdaM & ~sda_oe;

    int         checkCount = 0;
    int         passCount = 0;
    int         addrHits = 0;
    int         stops = 0;
    int         oeSeen = 0;
    logic [8:0] expQ[$];

    i2c_target_rx #(
        .TGT_ADDR    (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (sclM),
        .sda_i    (sdaBus),
        .sda_oe   (sda_oe),
        .enable   (enable),
        .rx_data  (rx_data),
        .rx_first (rx_first),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .addr_hit (addr_hit),
        .stop_det (stop_det),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        sdaM = 1'b0; waitClk(Q);
        sclM = 1'b0; waitClk(Q);
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        sdaM = 1'b1; waitClk(Q);
    endtask

    task automatic sendBits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sdaM = b[i]; waitClk(Q);
            sclM = 1'b1; waitClk(2 * Q);
            sclM = 1'b0; waitClk(Q);
        end
    endtask

    task automatic ackPhase(output logic acked);
        sdaM = 1'b1; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        acked = ~sdaBus;
        waitClk(Q);
        sclM = 1'b0; waitClk(Q);
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] b, input logic expAck);
        logic acked;
        sendBits(b);
        ackPhase(acked);
        checkOutput(tag, 32'(acked), 32'(expAck));
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && expQ.size() != 0; i++) waitClk(1);
        checkOutput("drain", expQ.size(), 0);
    endtask

    task automatic clearCounters();
        addrHits = 0;
        stops = 0;
        oeSeen = 0;
    endtask

    // Bus/stream monitor, sampled on the falling clock edge away from DUT updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (sda_oe) oeSeen++;
            if (addr_hit) addrHits++;
            if (stop_det) stops++;
            if (rx_valid && rx_ready) begin
                if (expQ.size() == 0) checkOutput("unexpected_byte", {23'd0, rx_first, rx_data}, 32'h1ff);
                else checkOutput("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, expQ.pop_front()});
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acked;
        waitClk(3);
        checkOutput("reset_outputs", {sda_oe, rx_valid, rx_data, rx_first, addr_hit, stop_det, overflow, busy}, 0);
        rst = 1'b0;
        waitClk(4);

        // Basic write with two data bytes
        clearCounters();
        i2cStart();
        applyStimulus("basic_addr_ack", 8'hA0, 1'b1);
        checkOutput("basic_busy", busy, 1);
        expQ.push_back({1'b1, 8'h3C});
        applyStimulus("basic_d0_ack", 8'h3C, 1'b1);
        expQ.push_back({1'b0, 8'hC3});
        applyStimulus("basic_d1_ack", 8'hC3, 1'b1);
        i2cStop();
        waitClk(10);
        checkOutput("basic_addr_hits", addrHits, 1);
        checkOutput("basic_stops", stops, 1);
        checkOutput("basic_busy_end", busy, 0);
        waitDrain();

        // Address mismatch
        clearCounters();
        i2cStart();
        applyStimulus("mismatch_addr_nack", 8'hA2, 1'b0);
        applyStimulus("mismatch_data_nack", 8'h55, 1'b0);
        i2cStop();
        waitClk(10);
        checkOutput("mismatch_oe_seen", oeSeen, 0);
        checkOutput("mismatch_addr_hits", addrHits, 0);
        checkOutput("mismatch_stops", stops, 1);
        checkOutput("mismatch_valid", rx_valid, 0);

        // Read direction is not served
        clearCounters();
        i2cStart();
        applyStimulus("read_addr_nack", 8'hA1, 1'b0);
        checkOutput("read_busy", busy, 0);
        i2cStop();
        waitClk(10);
        checkOutput("read_addr_hits", addrHits, 0);

        // Disabled target never ACKs
        enable = 1'b0;
        i2cStart();
        applyStimulus("disabled_addr_nack", 8'hA0, 1'b0);
        i2cStop();
        enable = 1'b1;
        waitClk(10);

        // Overflow: consumer stalled
        checkOutput("overflow_pre", overflow, 0);
        rx_ready = 1'b0;
        i2cStart();
        applyStimulus("ovf_addr_ack", 8'hA0, 1'b1);
        expQ.push_back({1'b1, 8'h11});
        applyStimulus("ovf_d0_ack", 8'h11, 1'b1);
        applyStimulus("ovf_d1_nack", 8'h22, 1'b0);
        i2cStop();
        waitClk(10);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_held_valid", rx_valid, 1);
        checkOutput("ovf_held_data", rx_data, 8'h11);
        rx_ready = 1'b1;
        waitDrain();
        waitClk(5);
        checkOutput("ovf_valid_clear", rx_valid, 0);
        checkOutput("ovf_sticky", overflow, 1);

        // Repeated START
        clearCounters();
        i2cStart();
        applyStimulus("sr_addr0_ack", 8'hA0, 1'b1);
        expQ.push_back({1'b1, 8'h01});
        applyStimulus("sr_d0_ack", 8'h01, 1'b1);
        i2cStart();
        applyStimulus("sr_addr1_ack", 8'hA0, 1'b1);
        expQ.push_back({1'b1, 8'h02});
        applyStimulus("sr_d1_ack", 8'h02, 1'b1);
        i2cStop();
        waitClk(10);
        checkOutput("sr_addr_hits", addrHits, 2);
        checkOutput("sr_stops", stops, 1);
        waitDrain();

        // Reset asserted while the target is driving ACK
        i2cStart();
        sendBits(8'hA0);
        sdaM = 1'b1;
        waitClk(Q);
        checkOutput("rst_oe_before", sda_oe, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_oe_async", sda_oe, 0);
        waitClk(3);
        checkOutput("rst_overflow_clr", overflow, 0);
        rst = 1'b0;
        waitClk(Q);
        clearCounters();
        sendBits(8'hA0);
        ackPhase(acked);
        checkOutput("rst_idle_nack", 32'(acked), 0);
        checkOutput("rst_idle_busy", busy, 0);
        i2cStart();
        applyStimulus("rst_recover_addr", 8'hA0, 1'b1);
        expQ.push_back({1'b1, 8'h77});
        applyStimulus("rst_recover_data", 8'h77, 1'b1);
        i2cStop();
        waitClk(10);
        checkOutput("rst_recover_hits", addrHits, 1);
        waitDrain();

        waitClk(10);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
